// File: rtl/de0_stim_gen.sv
// de0_stim_gen: on-board stimulus sequencer for de0_training.
// Plays a fixed 544-step sweep (two single-operand sweeps, then two
// 16x16 cross sweeps). Each vector is held for STEP_DIV cycles, and every
// output comes straight from a register.
module de0_stim_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] din_0,
  output logic [3:0] din_1,
  output logic [1:0] sel,
  output logic       valid,
  output logic [9:0] step_idx,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [9:0]       LAST_STEP = 10'd543;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [9:0]       step_reg, step_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       step_inc;

  logic [3:0] din_0_next, din_1_next;
  logic [1:0] sel_next;
  logic       valid_next, busy_next, done_next;
  logic [9:0] step_idx_next;
  logic [9:0] vec_inc;

  // Maps a step number to {sel, din_0, din_1}. The cross-sweep operands are
  // slices of the offset counter, so they wrap modulo 16 without extra logic.
  function automatic logic [9:0] vec_of(input logic [9:0] s);
    logic [9:0] k2;
    logic [9:0] k3;
    k2 = s - 10'd32;
    k3 = s - 10'd288;
    if (s < 10'd16)
      vec_of = {2'd0, s[3:0], 4'd0};
    else if (s < 10'd32)
      vec_of = {2'd1, 4'd0, s[3:0]};
    else if (s < 10'd288)
      vec_of = {2'd2, k2[7:4], k2[3:0]};
    else
      vec_of = {2'd3, k3[7:4], k3[3:0]};
  endfunction

  assign step_inc = step_reg + 10'd1;
  assign vec_inc  = vec_of(step_inc);

  // Next-state and next-output logic. Outputs keep their value unless the
  // step changes, which is what freezes them during pause and mid-hold.
  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    div_next      = div_reg;
    din_0_next    = din_0;
    din_1_next    = din_1;
    sel_next      = sel;
    step_idx_next = step_idx;
    valid_next    = 1'b0;
    busy_next     = busy;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        din_0_next    = 4'd0;
        din_1_next    = 4'd0;
        sel_next      = 2'd0;
        step_idx_next = 10'd0;
        busy_next     = 1'b0;
        step_next     = 10'd0;
        div_next      = '0;
        if (start) begin
          // Step 0 is all zeros, so only the strobes need to change here.
          state_next = RUN;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end
      end

      RUN: begin
        if (!pause) begin
          if (div_reg == DIV_LAST) begin
            div_next = '0;
            if (step_reg == LAST_STEP) begin
              state_next    = DONE;
              step_next     = 10'd0;
              din_0_next    = 4'd0;
              din_1_next    = 4'd0;
              sel_next      = 2'd0;
              step_idx_next = 10'd0;
              busy_next     = 1'b0;
              done_next     = 1'b1;
            end else begin
              step_next     = step_inc;
              step_idx_next = step_inc;
              {sel_next, din_0_next, din_1_next} = vec_inc;
              valid_next    = 1'b1;
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
      end

      DONE: begin
        state_next    = IDLE;
        din_0_next    = 4'd0;
        din_1_next    = 4'd0;
        sel_next      = 2'd0;
        step_idx_next = 10'd0;
        busy_next     = 1'b0;
      end

      default: begin
        state_next    = IDLE;
        din_0_next    = 4'd0;
        din_1_next    = 4'd0;
        sel_next      = 2'd0;
        step_idx_next = 10'd0;
        busy_next     = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs update together on one edge so phase
  // boundaries never show intermediate values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= 10'd0;
      div_reg   <= '0;
      din_0     <= 4'd0;
      din_1     <= 4'd0;
      sel       <= 2'd0;
      step_idx  <= 10'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      div_reg   <= div_next;
      din_0     <= din_0_next;
      din_1     <= din_1_next;
      sel       <= sel_next;
      step_idx  <= step_idx_next;
      valid     <= valid_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_de0_stim_gen.sv
// Testbench for de0_stim_gen: three instances (STEP_DIV = 1, 4, 3) checked
// every cycle against a timeline model, plus hand-computed spot checks.
module tb_de0_stim_gen;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[N];
  logic       start_s[N];
  logic       pause_s[N];
  logic [3:0] d0[N];
  logic [3:0] d1[N];
  logic [1:0] sl[N];
  logic       vl[N];
  logic [9:0] si[N];
  logic       bs[N];
  logic       dn[N];

  de0_stim_gen #(.STEP_DIV(1)) u0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .pause(pause_s[0]),
    .din_0(d0[0]), .din_1(d1[0]), .sel(sl[0]), .valid(vl[0]),
    .step_idx(si[0]), .busy(bs[0]), .done(dn[0]));

  de0_stim_gen #(.STEP_DIV(4)) u1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .pause(pause_s[1]),
    .din_0(d0[1]), .din_1(d1[1]), .sel(sl[1]), .valid(vl[1]),
    .step_idx(si[1]), .busy(bs[1]), .done(dn[1]));

  de0_stim_gen #(.STEP_DIV(3)) u2 (
    .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .pause(pause_s[2]),
    .din_0(d0[2]), .din_1(d1[2]), .sel(sl[2]), .valid(vl[2]),
    .step_idx(si[2]), .busy(bs[2]), .done(dn[2]));

  function automatic int div_of(input int i);
    case (i)
      0: div_of = 1;
      1: div_of = 4;
      default: div_of = 3;
    endcase
  endfunction

  // Vector for a given step, straight from the sweep description.
  function automatic void exp_vec(input int s, output int esel, output int ea, output int eb);
    if (s < 16) begin
      esel = 0; ea = s; eb = 0;
    end else if (s < 32) begin
      esel = 1; ea = 0; eb = s - 16;
    end else if (s < 288) begin
      esel = 2; ea = (s - 32) / 16; eb = (s - 32) % 16;
    end else begin
      esel = 3; ea = (s - 288) / 16; eb = (s - 288) % 16;
    end
  endfunction

  // Timeline model: mode 0 idle, 1 sweeping, 2 done. m_e counts the unpaused
  // sweep cycles elapsed; the current step is m_e / STEP_DIV.
  int m_mode[N];
  int m_e[N];
  bit m_fresh[N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_s[i]) begin
        m_mode[i] = 0; m_e[i] = 0; m_fresh[i] = 0;
      end else begin
        case (m_mode[i])
          0: begin
            m_fresh[i] = start_s[i];
            if (start_s[i]) begin
              m_mode[i] = 1; m_e[i] = 0;
            end
          end
          1: begin
            if (pause_s[i]) begin
              m_fresh[i] = 0;
            end else if (m_e[i] + 1 == 544 * div_of(i)) begin
              m_mode[i] = 2; m_fresh[i] = 0;
            end else begin
              m_e[i] = m_e[i] + 1;
              m_fresh[i] = ((m_e[i] % div_of(i)) == 0);
            end
          end
          default: begin
            m_mode[i] = 0; m_fresh[i] = 0;
          end
        endcase
      end
    end
  end

  int  compared = 0;
  int  mismatched = 0;
  bit  chk_en = 0;
  bit  pb[N];
  int  bcnt[N];
  int  vcnt[N];
  int  dwidth[N];
  int  dvalid[N];

  // Advances one cycle, then compares every instance against the model and
  // updates the busy/valid bookkeeping.
  task automatic tick();
    int s, esel, ea, eb, estep, ev, eb_busy, edn;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        if (m_mode[i] == 1) begin
          s = m_e[i] / div_of(i);
          exp_vec(s, esel, ea, eb);
          estep = s; ev = m_fresh[i] ? 1 : 0; eb_busy = 1; edn = 0;
        end else begin
          esel = 0; ea = 0; eb = 0; estep = 0; ev = 0; eb_busy = 0;
          edn = (m_mode[i] == 2) ? 1 : 0;
        end
        compared++;
        if (int'(sl[i]) != esel || int'(d0[i]) != ea || int'(d1[i]) != eb ||
            int'(si[i]) != estep || int'(vl[i]) != ev || int'(bs[i]) != eb_busy ||
            int'(dn[i]) != edn) begin
          mismatched++;
          if (mismatched <= 20)
            $display("FAIL cycle u%0d t=%0t: got sel=%0d d0=%0d d1=%0d step=%0d v=%0d busy=%0d done=%0d, expected sel=%0d d0=%0d d1=%0d step=%0d v=%0d busy=%0d done=%0d",
                     i, $time, sl[i], d0[i], d1[i], si[i], vl[i], bs[i], dn[i],
                     esel, ea, eb, estep, ev, eb_busy, edn);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bs[i] && !pb[i]) begin
        bcnt[i] = 0; vcnt[i] = 0;
      end
      if (bs[i]) bcnt[i]++;
      if (vl[i]) vcnt[i]++;
      if (dn[i]) begin
        dwidth[i] = bcnt[i]; dvalid[i] = vcnt[i];
      end
      pb[i] = bs[i];
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic wait_step(input int i, input int s);
    bit hit;
    hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      tick();
      if (int'(si[i]) == s && vl[i] && bs[i]) hit = 1;
    end
    chk($sformatf("reach_step u%0d s%0d", i, s), int'(hit), 1);
  endtask

  task automatic wait_done(input int i);
    bit hit;
    hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      tick();
      if (dn[i]) hit = 1;
    end
    chk($sformatf("reach_done u%0d", i), int'(hit), 1);
  endtask

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; pause_s[i] = 1'b0;
      pb[i] = 0; bcnt[i] = 0; vcnt[i] = 0; dwidth[i] = 0; dvalid[i] = 0;
    end

    // Reset for 3 cycles, then 20 idle cycles with start low.
    tick();
    chk_en = 1;
    tick();
    tick();
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    repeat (20) tick();
    chk("idle busy", int'(bs[0]), 0);
    chk("idle step_idx", int'(si[0]), 0);
    chk("idle sel", int'(sl[0]), 0);

    // STEP_DIV=1 full sweep.
    pulse_start(0);
    chk("d1 first valid", int'(vl[0]), 1);
    chk("d1 first sel", int'(sl[0]), 0);
    chk("d1 first din_0", int'(d0[0]), 0);
    chk("d1 first busy", int'(bs[0]), 1);
    wait_step(0, 15);
    chk("s15 din_0", int'(d0[0]), 15);
    wait_step(0, 16);
    chk("s16 sel", int'(sl[0]), 1);
    chk("s16 din_0", int'(d0[0]), 0);
    chk("s16 din_1", int'(d1[0]), 0);
    wait_step(0, 288);
    chk("s288 sel", int'(sl[0]), 3);
    chk("s288 din_0", int'(d0[0]), 0);
    chk("s288 din_1", int'(d1[0]), 0);
    wait_step(0, 543);
    chk("s543 din_0", int'(d0[0]), 15);
    chk("s543 din_1", int'(d1[0]), 15);
    wait_done(0);
    chk("d1 busy->done cycles", dwidth[0], 544);
    chk("d1 valid count", dvalid[0], 544);
    tick();

    // STEP_DIV=4: every vector held 4 cycles.
    pulse_start(1);
    wait_step(1, 1);
    chk("d4 step1 cycle", bcnt[1], 5);
    chk("d4 step1 din_0", int'(d0[1]), 1);
    wait_done(1);
    chk("d4 busy width", dwidth[1], 2176);
    chk("d4 valid count", dvalid[1], 544);
    tick();

    // STEP_DIV=3 with a 7-cycle pause in the middle of step 40's hold.
    pulse_start(2);
    wait_step(2, 40);
    tick();
    pause_s[2] = 1'b1;
    repeat (7) tick();
    chk("pause sel", int'(sl[2]), 2);
    chk("pause din_0", int'(d0[2]), 0);
    chk("pause din_1", int'(d1[2]), 8);
    chk("pause valid", int'(vl[2]), 0);
    chk("pause step_idx", int'(si[2]), 40);
    pause_s[2] = 1'b0;
    wait_done(2);
    chk("d3 busy width", dwidth[2], 1639);
    chk("d3 valid count", dvalid[2], 544);
    tick();

    // Reset in the middle of a sweep, then a fresh start.
    pulse_start(0);
    wait_step(0, 300);
    rst_s[0] = 1'b1;
    tick();
    chk("rst busy", int'(bs[0]), 0);
    chk("rst step_idx", int'(si[0]), 0);
    chk("rst sel", int'(sl[0]), 0);
    chk("rst din_0", int'(d0[0]), 0);
    rst_s[0] = 1'b0;
    pulse_start(0);
    chk("restart valid", int'(vl[0]), 1);
    chk("restart step_idx", int'(si[0]), 0);
    wait_done(0);
    tick();

    // start held high: auto-repeat, and a mid-sweep re-pulse is ignored.
    start_s[0] = 1'b1;
    tick();
    chk("held busy", int'(bs[0]), 1);
    wait_step(0, 100);
    start_s[0] = 1'b0;
    tick();
    start_s[0] = 1'b1;
    tick();
    chk("repulse step_idx", int'(si[0]), 102);
    wait_done(0);
    chk("held busy->done cycles", dwidth[0], 544);
    tick();
    chk("held idle busy", int'(bs[0]), 0);
    chk("held idle done", int'(dn[0]), 0);
    tick();
    chk("auto-repeat busy", int'(bs[0]), 1);
    chk("auto-repeat valid", int'(vl[0]), 1);
    chk("auto-repeat step_idx", int'(si[0]), 0);
    start_s[0] = 1'b0;
    wait_done(0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
